// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU ops pass through in one cycle; LD/ST hold a data-memory
// request until mem_ack arrives or the wait counter times out (sticky bus_error).
module mem_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  opcode,
   input  logic [19:0] aluRESULT,
   input  logic [19:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [19:0] mem_addr,
   output logic [19:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [19:0] mem_rdata,
   output logic        out_valid,
   output logic [3:0]  opcode_out,
   output logic [19:0] aluRESULTout,
   output logic [19:0] memory_read_data_out,
   output logic        bus_error
);

   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [7:0] TIMEOUT = 8'd255;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  wait_reg, wait_next;
   logic        mem_req_reg, mem_req_next;
   logic        mem_we_reg, mem_we_next;
   logic [19:0] mem_addr_reg, mem_addr_next;
   logic [19:0] mem_wdata_reg, mem_wdata_next;
   logic        out_valid_reg, out_valid_next;
   logic [3:0]  opcode_out_reg, opcode_out_next;
   logic [19:0] alu_out_reg, alu_out_next;
   logic [19:0] rdata_out_reg, rdata_out_next;
   logic        bus_error_reg, bus_error_next;
   logic        is_mem;

   assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);

   always_comb begin
      state_next      = state_reg;
      wait_next       = wait_reg;
      mem_req_next    = mem_req_reg;
      mem_we_next     = mem_we_reg;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      out_valid_next  = 1'b0;
      opcode_out_next = opcode_out_reg;
      alu_out_next    = alu_out_reg;
      rdata_out_next  = rdata_out_reg;
      bus_error_next  = bus_error_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (is_mem) begin
                  // Result outputs are left untouched until the access finishes.
                  state_next     = ACCESS;
                  wait_next      = 8'd0;
                  mem_req_next   = 1'b1;
                  mem_we_next    = (opcode == OP_ST);
                  mem_addr_next  = aluRESULT;
                  mem_wdata_next = (opcode == OP_ST) ? store_data : 20'd0;
               end else begin
                  out_valid_next  = 1'b1;
                  opcode_out_next = opcode;
                  alu_out_next    = aluRESULT;
                  rdata_out_next  = 20'd0;
               end
            end
         end
         ACCESS: begin
            // The pending opcode is recoverable from mem_we; the address doubles as ALU result.
            if (mem_ack || wait_reg == TIMEOUT - 8'd1) begin
               state_next      = IDLE;
               mem_req_next    = 1'b0;
               mem_we_next     = 1'b0;
               out_valid_next  = 1'b1;
               opcode_out_next = mem_we_reg ? OP_ST : OP_LD;
               alu_out_next    = mem_addr_reg;
               rdata_out_next  = (mem_ack && !mem_we_reg) ? mem_rdata : 20'd0;
               bus_error_next  = bus_error_reg | ~mem_ack;
            end else begin
               wait_next = wait_reg + 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         wait_reg       <= 8'd0;
         mem_req_reg    <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= 20'd0;
         mem_wdata_reg  <= 20'd0;
         out_valid_reg  <= 1'b0;
         opcode_out_reg <= 4'd0;
         alu_out_reg    <= 20'd0;
         rdata_out_reg  <= 20'd0;
         bus_error_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wait_reg       <= wait_next;
         mem_req_reg    <= mem_req_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         out_valid_reg  <= out_valid_next;
         opcode_out_reg <= opcode_out_next;
         alu_out_reg    <= alu_out_next;
         rdata_out_reg  <= rdata_out_next;
         bus_error_reg  <= bus_error_next;
      end
   end

   assign in_ready             = (state_reg == IDLE);
   assign mem_req              = mem_req_reg;
   assign mem_we               = mem_we_reg;
   assign mem_addr             = mem_addr_reg;
   assign mem_wdata            = mem_wdata_reg;
   assign out_valid            = out_valid_reg;
   assign opcode_out           = opcode_out_reg;
   assign aluRESULTout         = alu_out_reg;
   assign memory_read_data_out = rdata_out_reg;
   assign bus_error            = bus_error_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single instructions plus
// hand-written sequences for timeout, reset-in-ACCESS and back-to-back flow.
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [19:0] aluRESULT;
   logic [19:0] store_data;
   logic        mem_req;
   logic        mem_we;
   logic [19:0] mem_addr;
   logic [19:0] mem_wdata;
   logic        mem_ack;
   logic [19:0] mem_rdata;
   logic        out_valid;
   logic [3:0]  opcode_out;
   logic [19:0] aluRESULTout;
   logic [19:0] memory_read_data_out;
   logic        bus_error;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   mem_stage dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .aluRESULT(aluRESULT), .store_data(store_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .opcode_out(opcode_out), .aluRESULTout(aluRESULTout),
      .memory_read_data_out(memory_read_data_out), .bus_error(bus_error)
   );

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [19:0] alu;
      logic [19:0] sd;
      int          ack_wait;   // ACCESS cycles without ack before the ack cycle
      logic [19:0] rdata;
      logic        exp_mem;
      logic        exp_we;
      logic [19:0] exp_wdata;
      logic [19:0] exp_rdata_out;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply(input vec_t v);
      in_valid = 1'b1; opcode = v.op; aluRESULT = v.alu; store_data = v.sd;
      chk({v.name, ".in_ready_before"}, 20'(in_ready), 20'd1);
      tick();
      in_valid = 1'b0;
      if (v.exp_mem) begin
         for (int i = 0; i <= v.ack_wait; i++) begin
            chk({v.name, ".mem_req"}, 20'(mem_req), 20'd1);
            chk({v.name, ".mem_addr"}, mem_addr, v.alu);
            chk({v.name, ".mem_we"}, 20'(mem_we), 20'(v.exp_we));
            chk({v.name, ".mem_wdata"}, mem_wdata, v.exp_wdata);
            chk({v.name, ".in_ready_access"}, 20'(in_ready), 20'd0);
            chk({v.name, ".no_early_valid"}, 20'(out_valid), 20'd0);
            mem_ack = (i == v.ack_wait);
            mem_rdata = v.rdata;
            tick();
         end
         mem_ack = 1'b0;
         chk({v.name, ".mem_req_drop"}, 20'(mem_req), 20'd0);
         chk({v.name, ".mem_we_drop"}, 20'(mem_we), 20'd0);
      end
      chk({v.name, ".out_valid"}, 20'(out_valid), 20'd1);
      chk({v.name, ".opcode_out"}, 20'(opcode_out), 20'(v.op));
      chk({v.name, ".aluRESULTout"}, aluRESULTout, v.alu);
      chk({v.name, ".rdata_out"}, memory_read_data_out, v.exp_rdata_out);
      chk({v.name, ".in_ready_after"}, 20'(in_ready), 20'd1);
      tick();
      chk({v.name, ".single_pulse"}, 20'(out_valid), 20'd0);
      chk({v.name, ".hold_alu"}, aluRESULTout, v.alu);
      $display("[TB] vector %s done (tests %0d, failed %0d)", v.name, tests, fails);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{"alu_abc",   4'b0001, 20'h00ABC, 20'h00000, 0, 20'h00000, 1'b0, 1'b0, 20'h00000, 20'h00000};
      vecs[1] = '{"ld_wait3",  4'b0100, 20'h00010, 20'h77777, 2, 20'h12345, 1'b1, 1'b0, 20'h00000, 20'h12345};
      vecs[2] = '{"st_imm",    4'b0101, 20'h00020, 20'hBEEF0, 0, 20'h00000, 1'b1, 1'b1, 20'hBEEF0, 20'h00000};
      vecs[3] = '{"alu_max",   4'b1111, 20'hFFFFF, 20'h00000, 0, 20'h00000, 1'b0, 1'b0, 20'h00000, 20'h00000};
      vecs[4] = '{"ld_imm",    4'b0100, 20'hFFFFF, 20'h00000, 0, 20'hFFFFF, 1'b1, 1'b0, 20'h00000, 20'hFFFFF};
      vecs[5] = '{"st_rdbus",  4'b0101, 20'h00001, 20'h0000A, 4, 20'h55555, 1'b1, 1'b1, 20'h0000A, 20'h00000};
      vecs[6] = '{"alu_zero",  4'b0000, 20'h00000, 20'h00000, 0, 20'h00000, 1'b0, 1'b0, 20'h00000, 20'h00000};

      reset = 1'b1; in_valid = 1'b0; opcode = 4'd0; aluRESULT = 20'd0;
      store_data = 20'd0; mem_ack = 1'b0; mem_rdata = 20'd0;
      tick(); tick();
      reset = 1'b0;
      chk("rst.in_ready", 20'(in_ready), 20'd1);
      chk("rst.mem_req", 20'(mem_req), 20'd0);
      chk("rst.mem_addr", mem_addr, 20'd0);
      chk("rst.out_valid", 20'(out_valid), 20'd0);
      chk("rst.opcode_out", 20'(opcode_out), 20'd0);
      chk("rst.rdata_out", memory_read_data_out, 20'd0);
      chk("rst.bus_error", 20'(bus_error), 20'd0);
      tick();

      foreach (vecs[i]) apply(vecs[i]);

      // Ack while idle must be ignored.
      mem_ack = 1'b1; mem_rdata = 20'h9ABCD;
      tick(); tick();
      mem_ack = 1'b0;
      chk("idle_ack.out_valid", 20'(out_valid), 20'd0);
      chk("idle_ack.rdata_out", memory_read_data_out, 20'd0);
      chk("idle_ack.mem_req", 20'(mem_req), 20'd0);
      chk("idle_ack.in_ready", 20'(in_ready), 20'd1);
      $display("[TB] idle ack sequence done");

      // Timeout: LD never acked aborts after 255 ACCESS cycles.
      in_valid = 1'b1; opcode = 4'b0100; aluRESULT = 20'h00030;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (mem_req === 1'b1 && n < 300) begin
         n++;
         tick();
      end
      chk("timeout.req_cycles", 20'(n), 20'd255);
      chk("timeout.out_valid", 20'(out_valid), 20'd1);
      chk("timeout.rdata_out", memory_read_data_out, 20'd0);
      chk("timeout.bus_error", 20'(bus_error), 20'd1);
      chk("timeout.in_ready", 20'(in_ready), 20'd1);
      tick();
      chk("timeout.single_pulse", 20'(out_valid), 20'd0);
      apply(vecs[0]);
      chk("timeout.sticky", 20'(bus_error), 20'd1);
      $display("[TB] timeout sequence done");

      // Ack on the 255th ACCESS cycle wins over timeout.
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst2.bus_error", 20'(bus_error), 20'd0);
      in_valid = 1'b1; opcode = 4'b0100; aluRESULT = 20'h00040;
      tick();
      in_valid = 1'b0;
      n = 0;
      for (int c = 1; c <= 255; c++) begin
         if (mem_req === 1'b1) n++;
         mem_ack = (c == 255);
         mem_rdata = 20'h0A5A5;
         tick();
      end
      mem_ack = 1'b0;
      chk("late_ack.req_cycles", 20'(n), 20'd255);
      chk("late_ack.out_valid", 20'(out_valid), 20'd1);
      chk("late_ack.rdata_out", memory_read_data_out, 20'h0A5A5);
      chk("late_ack.bus_error", 20'(bus_error), 20'd0);
      tick();
      $display("[TB] ack-at-timeout sequence done");

      // Reset on the second ACCESS cycle, then a stray ack.
      in_valid = 1'b1; opcode = 4'b0100; aluRESULT = 20'h00050;
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 20'h11111;
      chk("rst_acc.mem_req", 20'(mem_req), 20'd0);
      chk("rst_acc.out_valid", 20'(out_valid), 20'd0);
      chk("rst_acc.in_ready", 20'(in_ready), 20'd1);
      chk("rst_acc.mem_addr", mem_addr, 20'd0);
      chk("rst_acc.alu_out", aluRESULTout, 20'd0);
      chk("rst_acc.opcode_out", 20'(opcode_out), 20'd0);
      tick();
      mem_ack = 1'b0;
      chk("rst_acc.no_valid", 20'(out_valid), 20'd0);
      chk("rst_acc.rdata_out", memory_read_data_out, 20'd0);
      chk("rst_acc.in_ready2", 20'(in_ready), 20'd1);
      $display("[TB] reset-in-access sequence done");

      // Back-to-back ALU, LD (1-cycle ack), ALU with in_valid held high.
      in_valid = 1'b1; opcode = 4'b0010; aluRESULT = 20'h00111;
      tick();
      chk("b2b.alu1_valid", 20'(out_valid), 20'd1);
      chk("b2b.alu1_result", aluRESULTout, 20'h00111);
      chk("b2b.alu1_ready", 20'(in_ready), 20'd1);
      opcode = 4'b0100; aluRESULT = 20'h00222;
      tick();
      chk("b2b.ld_novalid", 20'(out_valid), 20'd0);
      chk("b2b.ld_ready", 20'(in_ready), 20'd0);
      chk("b2b.ld_req", 20'(mem_req), 20'd1);
      mem_ack = 1'b1; mem_rdata = 20'h33333;
      tick();
      mem_ack = 1'b0;
      chk("b2b.ld_valid", 20'(out_valid), 20'd1);
      chk("b2b.ld_rdata", memory_read_data_out, 20'h33333);
      chk("b2b.ld_opcode", 20'(opcode_out), 20'h4);
      chk("b2b.ld_addr", aluRESULTout, 20'h00222);
      chk("b2b.ld_ready_after", 20'(in_ready), 20'd1);
      opcode = 4'b0011; aluRESULT = 20'h00444;
      tick();
      in_valid = 1'b0;
      chk("b2b.alu2_valid", 20'(out_valid), 20'd1);
      chk("b2b.alu2_result", aluRESULTout, 20'h00444);
      chk("b2b.alu2_rdata", memory_read_data_out, 20'd0);
      tick();
      chk("b2b.end_novalid", 20'(out_valid), 20'd0);
      $display("[TB] back-to-back sequence done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset, sampled on posedge clock.
REQ-003 SHALL have: in_valid  in  1  upstream instruction present.
REQ-004 SHALL have: in_ready  out  1  stage can accept; upstream holds inputs while low.
REQ-005 SHALL have: opcode  in  4  instruction opcode.
REQ-006 SHALL have: aluRESULT  in  20  ALU result; memory address for LD/ST.
REQ-007 SHALL have: store_data  in  20  write data for ST.
REQ-008 SHALL have: mem_req, mem_we  out  1 each  data-memory request and write enable.
REQ-009 SHALL have: mem_addr, mem_wdata  out  20 each  data-memory address and write data.
REQ-010 SHALL have: mem_ack  in  1; mem_rdata  in  20  memory completion and read data.
REQ-011 SHALL have: out_valid  out  1  one-cycle pulse, new result for MEM/WB register.
REQ-012 SHALL have: opcode_out 4, aluRESULTout 20, memory_read_data_out 20  out  results to MEM/WB.
REQ-013 SHALL have: bus_error  out  1  sticky memory-timeout flag.
REQ-014 SHALL use constants: OP_LD = 4'b0100, OP_ST = 4'b0101, TIMEOUT = 255 cycles.

Function
REQ-015 SHALL implement states IDLE and ACCESS; in_ready = 1 exactly when state is IDLE.
REQ-016 SHALL accept an instruction on a posedge where in_valid && in_ready.
REQ-017 Non-memory opcode accepted: SHALL, on the accept edge, load opcode_out/aluRESULTout, set memory_read_data_out = 0, pulse out_valid in the following cycle, remain IDLE (latency 1, throughput 1/cycle).
REQ-018 LD/ST accepted: SHALL, on the accept edge, register mem_addr = aluRESULT, mem_wdata = store_data (ST) or 0 (LD), mem_we = (opcode==OP_ST), mem_req = 1, wait counter = 0, enter ACCESS.
REQ-019 In ACCESS, mem_req, mem_we, mem_addr, mem_wdata SHALL remain stable until the completing edge.
REQ-020 mem_ack sampled high in ACCESS SHALL complete: mem_req = 0, mem_we = 0, memory_read_data_out = mem_rdata (LD) or 0 (ST), opcode_out/aluRESULTout updated, out_valid pulsed next cycle, return to IDLE.
REQ-021 Minimum LD/ST latency SHALL be 2 edges from accept to out_valid (ack on first ACCESS cycle).
REQ-022 In ACCESS without ack, the 8-bit wait counter SHALL increment each cycle; at count 255 without ack SHALL abort: mem_req = 0, memory_read_data_out = 0, out_valid pulsed, bus_error = 1, return IDLE.
REQ-023 mem_ack on the timeout cycle SHALL win: normal completion, bus_error unchanged.
REQ-024 mem_ack while IDLE SHALL be ignored (no state or output change).
REQ-025 in_valid while in ACCESS SHALL be ignored; no accept occurs.
REQ-026 Result outputs SHALL hold their last value between out_valid pulses; out_valid SHALL never be high two cycles per instruction.
REQ-027 bus_error SHALL remain set until reset.

Reset
REQ-028 Reset SHALL force: state IDLE, in_ready 1, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, out_valid 0, opcode_out 0, aluRESULTout 0, memory_read_data_out 0, bus_error 0, wait counter 0.
REQ-029 Reset during ACCESS SHALL drop mem_req on that edge, discard the pending instruction, produce no out_valid; a late mem_ack after reset SHALL be ignored.
REQ-030 Reset SHALL take priority over accept, ack and timeout on the same edge.

Verification
REQ-031 ALU op 4'b0001, aluRESULT 20'h00ABC, in_valid 1 cycle -> next cycle out_valid 1, aluRESULTout 20'h00ABC, memory_read_data_out 0, in_ready stays 1.
REQ-032 LD addr 20'h00010, mem_ack after 3 ACCESS cycles with mem_rdata 20'h12345 -> mem_req high 3 cycles with stable addr, in_ready 0, then out_valid 1, memory_read_data_out 20'h12345.
REQ-033 ST addr 20'h00020, store_data 20'hBEEF0, immediate ack -> mem_we 1, mem_wdata 20'hBEEF0 for 1 cycle, out_valid 1, memory_read_data_out 0.
REQ-034 LD with mem_ack never asserted -> abort after 255 ACCESS cycles, out_valid 1, memory_read_data_out 0, bus_error 1 and sticky; repeat with ack on cycle 255 -> normal completion, bus_error 0.
REQ-035 Reset asserted on 2nd ACCESS cycle of an LD, ack next cycle -> mem_req 0 after reset edge, no out_valid, all outputs at reset values.
REQ-036 Back-to-back: ALU, LD (ack 1 cycle), ALU with in_valid held -> three out_valid pulses in order, in_ready low only during ACCESS.
